// File: rtl/mul_arb_pkg.sv
// rtl/mul_arb_pkg.sv - shared FSM state type and counter width for the shared-multiplier arbiter
package mul_arb_pkg;

    localparam int OP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mul_share_arb_if.sv
// rtl/mul_share_arb_if.sv - request/response bundle between requesters and the shared multiplier
interface mul_share_arb_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0]      req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0]      req_b;
    logic [NUM_REQ-1:0]                 req_ready;
    logic                               rsp_valid;
    logic                               rsp_ready;
    logic [ID_W-1:0]                    rsp_id;
    logic [2*DATA_WIDTH-1:0]            rsp_result;
    logic                               busy;
    logic [mul_arb_pkg::OP_CNT_W-1:0]   op_count;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, busy, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, busy, op_count
    );

endinterface

// File: rtl/mul_core.sv
// rtl/mul_core.sv - combinational unsigned multiplier, full-width product
module mul_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [2*DATA_WIDTH-1:0] result
);

    assign result = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);

endmodule

// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - round-robin arbiter sharing one multiplier among NUM_REQ requesters
module mul_share_arb
    import mul_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic            clk,
    input  logic            rst,
    mul_share_arb_if.slave  bus
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW   = 2 * DATA_WIDTH;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q;
    logic [ID_W-1:0]        id_q;
    logic [DATA_WIDTH-1:0]  a_q, b_q;
    logic [PW-1:0]          result_q;
    logic [PW-1:0]          product;
    logic [OP_CNT_W-1:0]    op_count_q;

    logic [ID_W:0]          pick;
    logic [ID_W-1:0]        winner;
    logic [ID_W-1:0]        next_ptr;
    logic                   handshake;
    logic                   grant_en;
    logic                   accept;
    logic [NUM_REQ-1:0]     req_ready_c;

    // Returns {found, index}; scans from ptr upward so the lowest offset wins.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [ID_W-1:0]    ptr);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (valid[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        pick = rr_pick(bus.req_valid, rr_ptr_q);
    end

    assign winner    = pick[ID_W-1:0];
    assign next_ptr  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign handshake = (state_q == RESP) && bus.rsp_ready;
    // A grant can be issued from IDLE or in the same cycle the response retires.
    assign grant_en  = (state_q == IDLE) || handshake;
    assign accept    = grant_en && pick[ID_W];

    always_comb begin
        req_ready_c = '0;
        if (accept) begin
            req_ready_c[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                state_d = RESP;
            end
            RESP: begin
                if (handshake) begin
                    state_d = accept ? CALC : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mul_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul_core (
        .a      (a_q),
        .b      (b_q),
        .result (product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q      <= bus.req_a[winner*DATA_WIDTH +: DATA_WIDTH];
                b_q      <= bus.req_b[winner*DATA_WIDTH +: DATA_WIDTH];
                id_q     <= winner;
                rr_ptr_q <= next_ptr;
            end
            if (state_q == CALC) begin
                result_q <= product;
            end
            if (handshake && (op_count_q != '1)) begin
                op_count_q <= op_count_q + 1'b1;
            end
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// tb/tb_mul_share_arb.sv - directed self-checking bench for mul_share_arb
module tb_mul_share_arb;
    import mul_arb_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    mul_share_arb_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus ();

    mul_share_arb #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        step();
        step();
        tests++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.busy, bus.op_count} !== 40'd0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b v=%b id=%0d res=%0d busy=%b cnt=%0d, want all zero",
                     bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.busy, bus.op_count);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        bus.req_valid = 4'b0001;
        bus.req_a = {8'd0, 8'd0, 8'd0, 8'd11};
        bus.req_b = {8'd0, 8'd0, 8'd0, 8'd12};
        bus.rsp_ready = 1'b1;
        #1;
        tests++;
        if (bus.req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL single_grant: got %b want 0001", bus.req_ready);
        end
        step();
        bus.req_valid = '0;
        #1;
        tests++;
        if ({bus.busy, bus.rsp_valid, bus.req_ready} !== 6'b100000) begin
            fails++;
            $display("FAIL single_calc: got busy=%b v=%b rdy=%b want 1 0 0000", bus.busy, bus.rsp_valid, bus.req_ready);
        end
        step();
        tests++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result} !== {1'b1, 2'd0, 16'd132}) begin
            fails++;
            $display("FAIL single_rsp: got v=%b id=%0d res=%0d want 1 0 132", bus.rsp_valid, bus.rsp_id, bus.rsp_result);
        end
        step();
        tests++;
        if ({bus.rsp_valid, bus.busy, bus.op_count} !== {1'b0, 1'b0, 16'd1}) begin
            fails++;
            $display("FAIL single_done: got v=%b busy=%b cnt=%0d want 0 0 1", bus.rsp_valid, bus.busy, bus.op_count);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] prod [4];
        logic [3:0]  exp_gnt;
        prod = '{16'd20, 16'd60, 16'd120, 16'd200};
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_a = {8'd5, 8'd4, 8'd3, 8'd2};
        bus.req_b = {8'd40, 8'd30, 8'd20, 8'd10};
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            tests++;
            if (bus.req_ready !== exp_gnt) begin
                fails++;
                $display("FAIL rr_grant_%0d: got %b want %b", k, bus.req_ready, exp_gnt);
            end
            step();
            tests++;
            if ({bus.req_ready, bus.rsp_valid} !== 5'b00000) begin
                fails++;
                $display("FAIL rr_calc_%0d: got rdy=%b v=%b want 0000 0", k, bus.req_ready, bus.rsp_valid);
            end
            step();
            tests++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result} !== {1'b1, 2'(k % 4), prod[k % 4]}) begin
                fails++;
                $display("FAIL rr_rsp_%0d: got v=%b id=%0d res=%0d want 1 %0d %0d",
                         k, bus.rsp_valid, bus.rsp_id, bus.rsp_result, k % 4, prod[k % 4]);
            end
            if (k == 4) begin
                bus.req_valid = '0;
                #1;
            end
        end
        step();
        tests++;
        if ({bus.busy, bus.op_count} !== {1'b0, 16'd5}) begin
            fails++;
            $display("FAIL rr_done: got busy=%b cnt=%0d want 0 5", bus.busy, bus.op_count);
        end
    endtask

    task automatic test_backpressure();
        bus.req_a = {8'd0, 8'd0, 8'd255, 8'd0};
        bus.req_b = {8'd0, 8'd0, 8'd255, 8'd0};
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b0;
        #1;
        tests++;
        if (bus.req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL bp_grant: got %b want 0010", bus.req_ready);
        end
        step();
        bus.req_valid = 4'b1000;
        #1;
        tests++;
        if (bus.req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL bp_calc_ready: got %b want 0000", bus.req_ready);
        end
        step();
        for (int j = 0; j < 5; j++) begin
            tests++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.req_ready} !== {1'b1, 2'd1, 16'd65025, 4'b0000}) begin
                fails++;
                $display("FAIL bp_hold_%0d: got v=%b id=%0d res=%0d rdy=%b want 1 1 65025 0000",
                         j, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.req_ready);
            end
            step();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        #1;
        tests++;
        if ({bus.rsp_valid, bus.op_count} !== {1'b1, 16'd5}) begin
            fails++;
            $display("FAIL bp_pre_hs: got v=%b cnt=%0d want 1 5", bus.rsp_valid, bus.op_count);
        end
        step();
        step();
        tests++;
        if ({bus.rsp_valid, bus.op_count} !== {1'b0, 16'd6}) begin
            fails++;
            $display("FAIL bp_one_hs: got v=%b cnt=%0d want 0 6", bus.rsp_valid, bus.op_count);
        end
    endtask

    task automatic test_back_to_back();
        bus.req_a = {8'd9, 8'd200, 8'd0, 8'd0};
        bus.req_b = {8'd9, 8'd100, 8'd0, 8'd0};
        bus.req_valid = 4'b1000;
        bus.rsp_ready = 1'b1;
        #1;
        tests++;
        if (bus.req_ready !== 4'b1000) begin
            fails++;
            $display("FAIL b2b_first_grant: got %b want 1000", bus.req_ready);
        end
        step();
        bus.req_valid = 4'b0100;
        #1;
        step();
        tests++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result} !== {4'b0100, 1'b1, 2'd3, 16'd81}) begin
            fails++;
            $display("FAIL b2b_handoff: got rdy=%b v=%b id=%0d res=%0d want 0100 1 3 81",
                     bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result);
        end
        step();
        bus.req_valid = '0;
        #1;
        tests++;
        if ({bus.busy, bus.rsp_valid, dut.state_q} !== {1'b1, 1'b0, CALC}) begin
            fails++;
            $display("FAIL b2b_direct_calc: got busy=%b v=%b state=%0d want 1 0 1", bus.busy, bus.rsp_valid, dut.state_q);
        end
        step();
        tests++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result} !== {1'b1, 2'd2, 16'd20000}) begin
            fails++;
            $display("FAIL b2b_second_rsp: got v=%b id=%0d res=%0d want 1 2 20000", bus.rsp_valid, bus.rsp_id, bus.rsp_result);
        end
        step();
        tests++;
        if ({bus.busy, bus.op_count} !== {1'b0, 16'd8}) begin
            fails++;
            $display("FAIL b2b_done: got busy=%b cnt=%0d want 0 8", bus.busy, bus.op_count);
        end
    endtask

    task automatic test_reset_mid();
        bus.req_a = {8'd0, 8'd0, 8'd7, 8'd13};
        bus.req_b = {8'd0, 8'd0, 8'd6, 8'd13};
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        #1;
        tests++;
        if (bus.req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL rm_grant: got %b want 0001", bus.req_ready);
        end
        step();
        bus.req_valid = '0;
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.busy, bus.op_count} !== 40'd0) begin
            fails++;
            $display("FAIL rm_async_clear: got rdy=%b v=%b id=%0d res=%0d busy=%b cnt=%0d, want all zero",
                     bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.busy, bus.op_count);
        end
        step();
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tests++;
            if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
                fails++;
                $display("FAIL rm_no_rsp_%0d: got v=%b busy=%b want 0 0", j, bus.rsp_valid, bus.busy);
            end
            step();
        end
        bus.req_valid = 4'b0110;
        #1;
        tests++;
        if (bus.req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL rm_first_grant: got %b want 0010", bus.req_ready);
        end
        step();
        bus.req_valid = '0;
        #1;
        step();
        tests++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result} !== {1'b1, 2'd1, 16'd42}) begin
            fails++;
            $display("FAIL rm_after_rsp: got v=%b id=%0d res=%0d want 1 1 42", bus.rsp_valid, bus.rsp_id, bus.rsp_result);
        end
        step();
        tests++;
        if (bus.op_count !== 16'd1) begin
            fails++;
            $display("FAIL rm_count: got %0d want 1", bus.op_count);
        end
    endtask

    task automatic test_saturation();
        force dut.op_count_q = 16'hFFFE;
        #1;
        release dut.op_count_q;
        #1;
        tests++;
        if (bus.op_count !== 16'hFFFE) begin
            fails++;
            $display("FAIL sat_preload: got %h want fffe", bus.op_count);
        end
        bus.req_a = {8'd0, 8'd0, 8'd0, 8'd2};
        bus.req_b = {8'd0, 8'd0, 8'd0, 8'd3};
        bus.rsp_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            bus.req_valid = 4'b0001;
            #1;
            step();
            bus.req_valid = '0;
            #1;
            step();
            step();
            tests++;
            if (bus.op_count !== 16'hFFFF) begin
                fails++;
                $display("FAIL sat_hold_%0d: got %h want ffff", t, bus.op_count);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

endmodule
